// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, signed/unsigned per operation.
// Optional macro DIV_EARLY_EXIT_EN: a zero divisor skips the iteration phase.
//
// state | meaning
// IDLE  | waiting for start; result outputs hold the last completion
// RUN   | one shift/subtract iteration per edge, WIDTH iterations total
// FIX   | sign correction / divide-by-zero override, raises done
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic [2*WIDTH-1:0] result,
  output logic               dbz
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   counter;
  logic [WIDTH-1:0]   acc, q, dvs_mag, dvd_raw;
  logic               sign_q, sign_r, zero_div;

  logic               dvd_neg, dvs_neg;
  logic [WIDTH-1:0]   dvd_mag_in, dvs_mag_in;
  logic [WIDTH-1:0]   acc_sh, q_sh;
  logic [WIDTH:0]     diff;

  always_comb begin
    dvd_neg    = signed_mode & dividend[WIDTH-1];
    dvs_neg    = signed_mode & divisor[WIDTH-1];
    dvd_mag_in = dvd_neg ? (~dividend + WIDTH'(1)) : dividend;
    dvs_mag_in = dvs_neg ? (~divisor + WIDTH'(1)) : divisor;
    acc_sh     = {acc[WIDTH-2:0], q[WIDTH-1]};
    q_sh       = {q[WIDTH-2:0], 1'b0};
    // Extra top bit keeps the borrow visible for divisors >= 2^(WIDTH-1).
    diff       = {1'b0, acc_sh} - {1'b0, dvs_mag};
  end

  always_ff @(posedge clock) begin
    if (clear) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
`ifdef DIV_EARLY_EXIT_EN
          state_nxt = (divisor == '0) ? S_FIX : S_RUN;
`else
          state_nxt = S_RUN;
`endif
        end
      end
      S_RUN:   if (counter == CNT_W'(WIDTH-1)) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      counter   <= '0;
      acc       <= '0;
      q         <= '0;
      dvs_mag   <= '0;
      dvd_raw   <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      zero_div  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sign_q   <= signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            sign_r   <= dvd_neg;
            dvs_mag  <= dvs_mag_in;
            dvd_raw  <= dividend;
            zero_div <= (divisor == '0);
            acc      <= '0;
            q        <= dvd_mag_in;
            counter  <= '0;
          end
        end
        S_RUN: begin
          if (!diff[WIDTH]) begin
            acc <= diff[WIDTH-1:0];
            q   <= {q_sh[WIDTH-1:1], 1'b1};
          end else begin
            acc <= acc_sh;
            q   <= q_sh;
          end
          counter <= counter + CNT_W'(1);
        end
        S_FIX: begin
          if (zero_div) begin
            quotient  <= '1;
            remainder <= dvd_raw;
            dbz       <= 1'b1;
          end else begin
            quotient  <= sign_q ? (~q + WIDTH'(1)) : q;
            remainder <= sign_r ? (~acc + WIDTH'(1)) : acc;
            dbz       <= 1'b0;
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // done arrives while state is back in IDLE, so it extends busy by one cycle.
  assign busy   = (state != S_IDLE) | done;
  assign result = {remainder, quotient};

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=32); honours DIV_EARLY_EXIT_EN.
module tb_seq_divider;

  logic        clock = 1'b0;
  logic        clear, start, signed_mode;
  logic [31:0] dividend, divisor;
  logic        busy, done, dbz;
  logic [31:0] quotient, remainder;
  logic [63:0] result;

  int n_checks = 0;
  int n_pass   = 0;
  int lat;

`ifdef DIV_EARLY_EXIT_EN
  localparam int DBZ_LAT = 2;
`else
  localparam int DBZ_LAT = 34;
`endif

  seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .clear(clear), .start(start), .signed_mode(signed_mode),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .result(result), .dbz(dbz)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drives one start for a single edge; afterwards operands are scrambled.
  task automatic launch(input logic sm, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start = 1'b1; signed_mode = sm; dividend = a; divisor = b;
    @(posedge clock); #1;
    start = 1'b0; signed_mode = 1'($urandom); dividend = $urandom; divisor = $urandom;
  endtask

  // Counts edges (the start edge is edge 1) until done is seen, bounded.
  task automatic wait_done(input int edges_in, output int edges);
    edges = edges_in;
    while (!done && edges < 100) begin
      @(posedge clock); #1;
      edges++;
    end
  endtask

  task automatic run_op(input string tag, input logic sm, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_q,
                        input logic [31:0] exp_r, input logic exp_dbz, input int exp_lat);
    int e;
    launch(sm, a, b);
    wait_done(1, e);
    check({tag, "_latency"}, 64'(e), 64'(exp_lat));
    check({tag, "_quotient"}, 64'(quotient), 64'(exp_q));
    check({tag, "_remainder"}, 64'(remainder), 64'(exp_r));
    check({tag, "_dbz"}, 64'(dbz), 64'(exp_dbz));
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_dbz", 64'(dbz), 64'd0);
    clear = 1'b0;

    // 100/7 with handshake details
    launch(1'b0, 32'd100, 32'd7);
    check("u100_busy_after_start", 64'(busy), 64'd1);
    wait_done(1, lat);
    check("u100_latency", 64'(lat), 64'd34);
    check("u100_result", result, 64'h00000002_0000000E);
    check("u100_dbz", 64'(dbz), 64'd0);
    check("u100_busy_in_done", 64'(busy), 64'd1);
    @(posedge clock); #1;
    check("u100_done_width", 64'(done), 64'd0);
    check("u100_busy_after_done", 64'(busy), 64'd0);
    check("u100_hold", result, 64'h00000002_0000000E);

    run_op("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34);
    run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, 34);
    run_op("u_bigdiv", 1'b0, 32'hFFFFFFFF, 32'h80000001, 32'h00000001, 32'h7FFFFFFE, 1'b0, 34);
    run_op("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 34);
    run_op("u_neg_as_unsigned", 1'b0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'h00000001, 1'b0, 34);
    run_op("dbz_u", 1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1, DBZ_LAT);
    run_op("dbz_s", 1'b1, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1, DBZ_LAT);
    run_op("dbz_s_neg", 1'b1, 32'h87654321, 32'd0, 32'hFFFFFFFF, 32'h87654321, 1'b1, DBZ_LAT);
    run_op("after_dbz", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);

    // start pulsed mid-operation must be ignored
    launch(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clock);
    @(negedge clock);
    start = 1'b1; signed_mode = 1'b1; dividend = 32'd55; divisor = 32'd5;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(11, lat);
    check("ignore_latency", 64'(lat), 64'd34);
    check("ignore_result", result, 64'h00000002_0000000E);

    // back-to-back: launch in the done cycle
    launch(1'b0, 32'd1000, 32'd33);
    check("b2b_done_cleared", 64'(done), 64'd0);
    wait_done(1, lat);
    check("b2b_latency", 64'(lat), 64'd34);
    check("b2b_result", result, {32'd10, 32'd30});

    // clear mid-run aborts without a done pulse
    launch(1'b1, 32'hFFFFFF9C, 32'd7);
    repeat (13) @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_done", 64'(done), 64'd0);
    check("clr_quotient", 64'(quotient), 64'd0);
    check("clr_remainder", 64'(remainder), 64'd0);
    check("clr_result", result, 64'd0);
    check("clr_dbz", 64'(dbz), 64'd0);
    begin
      int seen = 0;
      repeat (40) begin
        @(posedge clock); #1;
        if (done) seen++;
      end
      check("clr_no_done", 64'(seen), 64'd0);
    end
    run_op("after_clr", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
